// File: rtl/key_event_gen.sv
// Push-button front end: two-flop synchronizer plus per-key debounce that
// emits clean press/release pulses and a debounced level on clk100_i.
//
// state       | meaning
// ------------+-----------------------------------------------
// ST_RELEASED | accepted level is released (key_i high)
// ST_PRESSED  | accepted level is pressed (key_i low)
module key_event_gen #(
    parameter int KEYS            = 2,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic            clk100_i,
    input  logic            arstn_i,
    input  logic [KEYS-1:0] key_i,
    output logic [KEYS-1:0] press_o,
    output logic [KEYS-1:0] release_o,
    output logic [KEYS-1:0] pressed_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        ST_RELEASED = 1'b0,
        ST_PRESSED  = 1'b1
    } state_t;

    logic [KEYS-1:0] sync1;
    logic [KEYS-1:0] sync2;

    // Reset to all ones so an idle (released) key looks unchanged after reset.
    always_ff @(posedge clk100_i or negedge arstn_i) begin
        if (!arstn_i) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= key_i;
            sync2 <= sync1;
        end
    end

    for (genvar k = 0; k < KEYS; k++) begin : g_key
        state_t        state_q;
        state_t        state_d;
        logic [CW-1:0] cnt_q;
        logic [CW-1:0] cnt_d;
        logic          press_q;
        logic          press_d;
        logic          release_q;
        logic          release_d;
        logic          raw_pressed;

        assign raw_pressed = ~sync2[k];

        always_ff @(posedge clk100_i or negedge arstn_i) begin
            if (!arstn_i) begin
                state_q   <= ST_RELEASED;
                cnt_q     <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                press_q   <= press_d;
                release_q <= release_d;
            end
        end

        always_comb begin
            state_d   = state_q;
            cnt_d     = '0;
            press_d   = 1'b0;
            release_d = 1'b0;
            case (state_q)
                ST_RELEASED: begin
                    if (raw_pressed) begin
                        if (cnt_q == CNT_LAST) begin
                            state_d = ST_PRESSED;
                            press_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                ST_PRESSED: begin
                    if (!raw_pressed) begin
                        if (cnt_q == CNT_LAST) begin
                            state_d   = ST_RELEASED;
                            release_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                default: state_d = ST_RELEASED;
            endcase
        end

        assign press_o[k]   = press_q;
        assign release_o[k] = release_q;
        assign pressed_o[k] = (state_q == ST_PRESSED);
    end

endmodule

// File: tb/tb_key_event_gen.sv
// Scoreboard bench for key_event_gen: each stimulus step queues the pulse it
// should cause; a negedge monitor pops and compares whenever a pulse appears.
module tb_key_event_gen;

    localparam int KEYS = 2;
    localparam int DEB  = 4;
    localparam int LAT  = DEB + 2;

    logic            clk = 1'b0;
    logic            arstn = 1'b0;
    logic [KEYS-1:0] key = 2'b11;
    logic [KEYS-1:0] press;
    logic [KEYS-1:0] rel;
    logic [KEYS-1:0] pressed;

    typedef struct {
        int              cyc;
        logic [KEYS-1:0] press;
        logic [KEYS-1:0] rel;
        logic [KEYS-1:0] lvl;
    } ev_t;

    ev_t             sb_q[$];
    ev_t             mon_ev;
    logic [KEYS-1:0] prev_lvl = '0;
    int              cyc = 0;
    int              n_cmp = 0;
    int              n_err = 0;

    key_event_gen #(.KEYS(KEYS), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk100_i (clk),
        .arstn_i  (arstn),
        .key_i    (key),
        .press_o  (press),
        .release_o(rel),
        .pressed_o(pressed)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!arstn) begin
            prev_lvl = '0;
        end else begin
            if ((press | rel) != '0) begin
                check_val("pulse_overlap", int'(press & rel), 0);
                if (sb_q.size() == 0) begin
                    check_val("unexpected_pulse", int'({press, rel}), 0);
                end else begin
                    mon_ev = sb_q.pop_front();
                    check_val("pulse_cycle", cyc, mon_ev.cyc);
                    check_val("press", int'(press), int'(mon_ev.press));
                    check_val("release", int'(rel), int'(mon_ev.rel));
                    check_val("pressed_level", int'(pressed), int'(mon_ev.lvl));
                end
            end else if (pressed != prev_lvl) begin
                check_val("level_without_pulse", int'(pressed), int'(prev_lvl));
            end
            prev_lvl = pressed;
        end
    end

    task automatic wait_drain();
        for (int i = 0; i < 4 * LAT && sb_q.size() != 0; i++) @(negedge clk);
        check_val("scoreboard_drain", sb_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    // Change key at a negedge; the following posedge is edge 0.
    task automatic drive(input logic [KEYS-1:0] v, input logic [KEYS-1:0] ep,
                         input logic [KEYS-1:0] er, input logic [KEYS-1:0] el);
        ev_t e;
        @(negedge clk);
        key = v;
        e.cyc = cyc + LAT;
        e.press = ep;
        e.rel = er;
        e.lvl = el;
        sb_q.push_back(e);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_press"}, int'(press), 0);
        check_val({tag, "_release"}, int'(rel), 0);
        check_val({tag, "_pressed"}, int'(pressed), 0);
    endtask

    initial begin
        ev_t e;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        arstn = 1'b1;
        repeat (100) @(negedge clk);
        check_idle_outputs("idle");

        // clean press then release on key 0
        drive(2'b10, 2'b01, 2'b00, 2'b01);
        wait_drain();
        repeat (20) @(negedge clk);
        drive(2'b11, 2'b00, 2'b01, 2'b00);
        wait_drain();

        // bounce: low 3 edges, high 1, low and held
        @(negedge clk);
        key = 2'b10;
        repeat (3) @(negedge clk);
        key = 2'b11;
        drive(2'b10, 2'b01, 2'b00, 2'b01);
        wait_drain();
        drive(2'b11, 2'b00, 2'b01, 2'b00);
        wait_drain();

        // simultaneous press and release of both keys
        drive(2'b00, 2'b11, 2'b00, 2'b11);
        wait_drain();
        drive(2'b11, 2'b00, 2'b11, 2'b00);
        wait_drain();

        // reset pulsed after edge 3 of a key 1 press
        @(negedge clk);
        key = 2'b01;
        repeat (4) @(negedge clk);
        arstn = 1'b0;
        @(negedge clk);
        check_idle_outputs("midreset");
        @(negedge clk);
        arstn = 1'b1;
        e.cyc = cyc + LAT;
        e.press = 2'b10;
        e.rel = 2'b00;
        e.lvl = 2'b10;
        sb_q.push_back(e);
        wait_drain();
        repeat (20) @(negedge clk);
        check_val("final_level", int'(pressed), 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/key_event_gen.md
Name: key_event_gen

Overview:
- Front end for the board push-buttons.
- Turns raw, bouncing, asynchronous, active-low key inputs into clean signals synchronous to clk100_i:
  - a single-cycle press pulse per key
  - a single-cycle release pulse per key
  - a debounced level per key
- Feeds downstream counters and registers, which then use only clk100_i edges and never key edges.

Parameters:
- KEYS, 2, number of independent key channels.
- DEBOUNCE_CYCLES, 1000000, consecutive stable samples required to accept a level change (10 ms at 100 MHz). Legal range ≥ 2.

Ports:
- clk100_i  input  1  system clock, 100 MHz.
- arstn_i  input  1  reset, asynchronous, active-low.
- key_i  input  KEYS  raw key levels, active-low (0 = pressed), asynchronous to clk100_i.
- press_o  output  KEYS  one-cycle pulse per key on accepted press.
- release_o  output  KEYS  one-cycle pulse per key on accepted release.
- pressed_o  output  KEYS  debounced level, 1 = pressed.

Behaviour:
- **Clock and reset**
  - Single clock domain; all registers clock on the rising edge of clk100_i.
  - arstn_i low clears everything immediately, independent of the clock.
- **Reset values**
  - sync stages = all 1 (released).
  - debounce counters = 0.
  - stable state = released.
  - press_o = 0, release_o = 0, pressed_o = 0.
- **Synchronizer**
  - Per key, two flops: key_i → s1 → s2.
  - Only s2 is used downstream.
- **Debounce, per key, independent**
  - Counter width is clog2(DEBOUNCE_CYCLES+1).
  - If s2 equals the stable state: counter is cleared to 0.
  - If s2 differs and counter < DEBOUNCE_CYCLES-1: counter increments.
  - If s2 differs and counter == DEBOUNCE_CYCLES-1: stable state flips, counter is cleared, and the matching pulse is registered for exactly one cycle (press_o on released→pressed, release_o on pressed→released).
  - A single sample equal to the stable state (a bounce) restarts the count from 0.
- **Latency**
  - Edge 0 is the first rising edge that samples the new key_i level, with the level held constant afterwards.
  - pressed_o changes and the pulse asserts after edge DEBOUNCE_CYCLES+1, i.e. the (DEBOUNCE_CYCLES+2)th edge.
  - pressed_o is registered and changes in the same cycle as the pulse.
- **Pulse rules**
  - press_o and release_o for the same key are never high together.
  - There is at most one pulse per accepted transition.
  - Holding a key produces no repeat pulses.
- **Multiple keys**
  - Keys are fully independent; simultaneous stable changes on several keys produce pulses in the same cycle.
- **Reset mid-operation**
  - Any in-progress count is discarded and no pulse is emitted on reset assertion or deassertion.
  - If a key is held low through reset, it is debounced afresh after arstn_i rises: press_o asserts DEBOUNCE_CYCLES+2 edges later.
- **Counter wrap**: impossible by construction; the counter never exceeds DEBOUNCE_CYCLES-1.

Test Plan (DEBOUNCE_CYCLES=4, KEYS=2):
- **Reset state**: arstn_i=0, key_i=2'b11 → all outputs 0. Release reset, hold keys 100 cycles → outputs stay 0.
- **Clean press**: key_i[0] 1→0 before edge 0, held → press_o[0] high for exactly the cycle after edge 5; pressed_o[0]=1 from the same cycle; press_o[1]=0 throughout.
- **Bounce**: key_i[0] low for 3 edges, high for 1, then low and held → no pulse during the bounce; press_o[0] asserts 6 edges after the final fall.
- **Release**: after a press, key_i[0] 0→1 and held → release_o[0] one cycle after edge 5; pressed_o[0] returns to 0; no press_o[0] pulse.
- **Simultaneous**: both keys fall on the same edge → press_o=2'b11 in the same single cycle.
- **Reset mid-count**: key_i[1] low, arstn_i pulsed low at edge 3 while held → no pulse; press_o[1] asserts 6 edges after arstn_i deasserts.
